// File: rtl/gate_exhaustive_checker.sv
// Exhaustive tester for an N-input AND/NAND/OR/NOR/XOR/XNOR cell: sweeps every input
// vector in binary order, waits a settle time per vector, samples and scores the cell output.
module gate_exhaustive_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 10,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              dut_zn,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              log_valid,
    output logic [N_IN-1:0]   log_vec,
    output logic              log_zn,
    output logic              log_fail,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid,
    output logic              done,
    output logic              pass,
    output logic              mode_err
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FIN} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_mode;
    logic [N_IN-1:0]    r_stim;
    logic [CNT_W-1:0]   r_cnt;
    logic [ERR_W-1:0]   r_err_count;
    logic [N_IN-1:0]    r_first_fail_vec;
    logic               r_first_fail_valid;
    logic               r_pass;
    logic               r_mode_err;

    logic               w_legal;
    logic               w_last;
    logic               w_expected;
    logic               w_fail;

    assign w_legal = (mode[2:1] != 2'b11);
    assign w_last  = &r_stim;

    always_comb begin
        w_expected = 1'b0;
        case (r_mode)
            3'd0:    w_expected =  (&r_stim);
            3'd1:    w_expected = ~(&r_stim);
            3'd2:    w_expected =  (|r_stim);
            3'd3:    w_expected = ~(|r_stim);
            3'd4:    w_expected =  (^r_stim);
            3'd5:    w_expected = ~(^r_stim);
            default: w_expected = 1'b0;
        endcase
    end

    // Case inequality so an X or Z from the cell is scored as a failure.
    assign w_fail = (dut_zn !== w_expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = w_legal ? S_SETTLE : S_FIN;
            S_SETTLE: if (r_cnt == '0) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = w_last ? S_FIN : S_SETTLE;
            S_FIN:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
        log_valid = (r_state == S_SAMPLE);
        log_vec   = log_valid ? r_stim : '0;
        log_zn    = log_valid & dut_zn;
        log_fail  = log_valid & w_fail;
        done      = (r_state == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode             <= 3'd0;
            r_stim             <= '0;
            r_cnt              <= '0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_mode_err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_mode             <= mode;
                        r_stim             <= '0;
                        r_cnt              <= CNT_LOAD;
                        r_err_count        <= '0;
                        r_first_fail_vec   <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_pass             <= 1'b0;
                        r_mode_err         <= 1'b0;
                    end else if (start) begin
                        r_mode_err <= 1'b1;
                        r_pass     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_SAMPLE: begin
                    if (w_fail) begin
                        if (!(&r_err_count)) r_err_count <= r_err_count + ERR_W'(1);
                        if (!r_first_fail_valid) begin
                            r_first_fail_vec   <= r_stim;
                            r_first_fail_valid <= 1'b1;
                        end
                    end
                    // Verdict is settled on the last sample so it is valid alongside done.
                    if (w_last) begin
                        r_pass <= (r_err_count == '0) && !w_fail;
                    end else begin
                        r_stim <= r_stim + N_IN'(1);
                        r_cnt  <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim             = r_stim;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;
    assign pass             = r_pass;
    assign mode_err         = r_mode_err;

endmodule

// File: doc/gate_exhaustive_checker.md
Name: gate_exhaustive_checker

Overview:
- Synthesizable, self-checking exhaustive tester for an N-input single-output combinational cell of the NAND/NOR/AND/OR/XOR/XNOR family.
- Sweeps all 2^N_IN input vectors in binary order, waits a programmable settle time per vector, and compares the cell output against the expected function.
- Reports a mismatch count, the first failing vector, pass/fail, and a per-vector log strobe.
- Sits beside a cell under test in cell-library characterisation benches and on-chip self-test wrappers.

Parameters:
N_IN, 3, number of cell inputs (legal 1..8)
SETTLE, 10, cycles each vector is held before sampling (legal >= 1)
ERR_W, 8, width of saturating mismatch counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  run request; sampled only in IDLE
mode  input  3  function: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 11x reserved
dut_zn  input  1  output of cell under test
stim  output  N_IN  drive to cell inputs; MSB = input 1 (A1)
busy  output  1  high while a sweep runs
log_valid  output  1  one-cycle strobe per sampled vector
log_vec  output  N_IN  vector sampled this cycle (valid with log_valid)
log_zn  output  1  dut_zn sampled this cycle
log_fail  output  1  mismatch on this sample
err_count  output  ERR_W  mismatches in the current or last run, saturating
first_fail_vec  output  N_IN  lowest failing vector of the current or last run
first_fail_valid  output  1  first_fail_vec holds a failing vector
done  output  1  one-cycle pulse at end of run
pass  output  1  last run finished with err_count == 0 and a legal mode
mode_err  output  1  last start used a reserved mode

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; all outputs = 0; mode register = 0. Applies from any state, including mid-sweep. The sweep is abandoned with no done pulse.
- States: IDLE, SETTLE, SAMPLE, FIN.
- IDLE, start=1, legal mode:
  - latch mode; clear err_count, first_fail_*, pass, mode_err;
  - stim=0; settle counter=SETTLE-1; busy=1; go to SETTLE.
- IDLE, start=1, reserved mode:
  - set mode_err=1, pass=0; go to FIN. No vectors are driven.
- SETTLE: decrement the counter. At 0, go to SAMPLE. stim is held constant.
- SAMPLE (exactly one cycle per vector):
  - expected = reduction of stim per latched mode (AND, ~AND, OR, ~OR, XOR, ~XOR);
  - fail = (dut_zn !== expected); X or Z on dut_zn counts as a failure;
  - drive log_valid=1 with log_vec=stim, log_zn=dut_zn, log_fail=fail;
  - on fail: err_count increments, saturating at 2^ERR_W-1. If first_fail_valid=0, capture first_fail_vec=stim and set first_fail_valid=1;
  - if stim is all ones, go to FIN; else stim+1, counter=SETTLE-1, go to SETTLE.
- FIN: done=1 for one cycle; busy=0; pass = legal mode and err_count==0 (computed including the final sample); go to IDLE. stim keeps its last value.
- Latency: each vector occupies SETTLE+1 cycles. busy is high for 2^N_IN*(SETTLE+1) cycles. done rises the cycle after the final SAMPLE.
- start outside IDLE is ignored. Mode changes during a run are ignored.
- Results (err_count, first_fail_*, pass, mode_err) hold until the next accepted start or reset.
- start asserted in the same cycle as rst_n=0: reset wins.

Test Plan:
- Defaults, mode=NAND, ideal NAND3 model on stim: 8 log_valid strobes with log_vec 000..111 and log_zn 1,1,1,1,1,1,1,0; busy high 88 cycles; done pulse; pass=1; err_count=0; first_fail_valid=0.
- mode=NAND, dut_zn stuck at 0: err_count=7; first_fail_vec=000; pass=0; log_fail=0 only for vector 111.
- N_IN=4, SETTLE=1, mode=XNOR, ideal XNOR4 model: 16 strobes, busy 32 cycles, pass=1. Then mode=XOR on the same model: err_count=16, first_fail_vec=0000.
- ERR_W=2, mode=AND, dut_zn stuck at 1: err_count saturates at 3; first_fail_vec=000; pass=0.
- rst_n=0 during vector 101 of a NAND run: next edge gives busy=0, stim=0, err_count=0, no done pulse. A new start gives a clean full run with pass=1.
- start with mode=110: done pulses on the cycle after the start edge; mode_err=1; pass=0; no log_valid. start pulses during busy produce no restart and no extra done.
